// File: rtl/rv_core_pkg.sv
// Shared core constants: PC sequencer state encoding and address defaults.
package rv_core_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam int unsigned        PC_STEP          = 4;
  localparam int unsigned        ADDR_W_DEF       = 64;
  localparam logic [ADDR_W_DEF-1:0] RESET_VECTOR_DEF = '0;

endpackage

// File: rtl/pc_wrap_align.sv
// Turns a candidate PC into the value actually loaded: word-aligned, and
// folded back to RESET_VECTOR when it falls outside instruction memory.
module pc_wrap_align #(
  parameter int unsigned       ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] PC_LIMIT     = ADDR_W'(16),
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic [ADDR_W-1:0] cand_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] aligned;

  assign aligned    = {cand_i[ADDR_W-1:2], 2'b00};
  assign misalign_o = (cand_i[1:0] != 2'b00);
  // The +4 path overflows modulo 2^ADDR_W into a small value only if PC_LIMIT
  // is huge; with any real limit the overflowed sum is already >= PC_LIMIT.
  assign wrap_o     = (aligned >= PC_LIMIT);
  assign addr_o     = wrap_o ? RESET_VECTOR : aligned;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot delay, +4 advance, branch redirects, stall with a
// pending-redirect slot, and halt/resume. Every PC update passes the wrap rule.
module pc_sequencer
  import rv_core_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] PC_LIMIT     = ADDR_W'(16),
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned       BOOT_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fetch_valid,
  output logic              wrapped,
  output logic              misaligned,
  output logic [1:0]        state
);

  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              wrap_q, mis_q;

  logic              upd, redir;
  logic [ADDR_W-1:0] cand, wa_addr;
  logic              wa_wrap, wa_mis;

  pc_wrap_align #(
    .ADDR_W       (ADDR_W),
    .PC_LIMIT     (PC_LIMIT),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_wrap_align (
    .cand_i     (cand),
    .addr_o     (wa_addr),
    .wrap_o     (wa_wrap),
    .misalign_o (wa_mis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      cnt_q        <= '0;
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      wrap_q       <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_next;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      wrap_q       <= upd & wa_wrap;
      mis_q        <= upd & redir & wa_mis;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    upd          = 1'b0;
    redir        = 1'b0;
    cand         = pc_q + ADDR_W'(PC_STEP);
    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (halt_req) state_d = ST_HALT;
        else if (branch_taken) begin
          upd   = 1'b1;
          redir = 1'b1;
          cand  = branch_target;
        end
        else if (stall) state_d = ST_STALL;
        else if (fetch_ready) upd = 1'b1;
      end
      ST_STALL: begin
        if (halt_req) state_d = ST_HALT;
        else if (!stall) begin
          // A branch arriving on the release cycle is newer than the pending one.
          state_d      = ST_RUN;
          pend_valid_d = 1'b0;
          if (branch_taken || pend_valid_q) begin
            upd   = 1'b1;
            redir = 1'b1;
            cand  = branch_taken ? branch_target : pend_addr_q;
          end
        end
        else if (branch_taken) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = branch_target;
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) begin
          state_d      = ST_RUN;
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            upd   = 1'b1;
            redir = 1'b1;
            cand  = pend_addr_q;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == ST_RUN);
    pc_next     = upd ? wa_addr : pc_q;
  end

  assign pc_out     = pc_q;
  assign wrapped    = wrap_q;
  assign misaligned = mis_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus a randomized run against a behavioural PC model.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W      = 64;
  localparam logic [63:0] LIMIT       = 64'd16;
  localparam logic [63:0] RVEC        = 64'd0;
  localparam int          BOOT_CYCLES = 2;
  localparam logic [1:0]  M_BOOT = 2'd0, M_RUN = 2'd1, M_STALL = 2'd2, M_HALT = 2'd3;

  logic              clk = 1'b0;
  logic              reset;
  logic              branch_taken, stall, halt_req, resume, fetch_ready;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc_out, pc_next;
  logic              fetch_valid, wrapped, misaligned;
  logic [1:0]        state;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]  mode;
    int          boot_left;
    logic [63:0] pc;
    bit          pend;
    logic [63:0] pend_addr;
    bit          wrap;
    bit          mis;
  } model_t;

  model_t      m;
  logic [63:0] seen_next, exp_next;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .halt_req      (halt_req),
    .resume        (resume),
    .fetch_ready   (fetch_ready),
    .pc_out        (pc_out),
    .pc_next       (pc_next),
    .fetch_valid   (fetch_valid),
    .wrapped       (wrapped),
    .misaligned    (misaligned),
    .state         (state)
  );

  always #5 clk = ~clk;

  function automatic model_t reset_model();
    model_t r;
    r.mode = M_BOOT; r.boot_left = BOOT_CYCLES; r.pc = RVEC;
    r.pend = 0; r.pend_addr = '0; r.wrap = 0; r.mis = 0;
    return r;
  endfunction

  // What the PC should become on the coming edge, derived from the rules.
  function automatic model_t next_model(model_t c);
    model_t      n;
    bit          go, rd;
    logic [63:0] tgt, a;
    n = c; n.wrap = 0; n.mis = 0;
    go = 0; rd = 0; tgt = c.pc + 64'd4;
    if (c.mode == M_BOOT) begin
      n.boot_left = c.boot_left - 1;
      if (n.boot_left == 0) n.mode = M_RUN;
    end else if (c.mode == M_RUN) begin
      if (halt_req) n.mode = M_HALT;
      else if (branch_taken) begin go = 1; rd = 1; tgt = branch_target; end
      else if (stall) n.mode = M_STALL;
      else if (fetch_ready) go = 1;
    end else if (c.mode == M_STALL) begin
      if (halt_req) n.mode = M_HALT;
      else if (!stall) begin
        n.mode = M_RUN; n.pend = 0;
        if (branch_taken) begin go = 1; rd = 1; tgt = branch_target; end
        else if (c.pend) begin go = 1; rd = 1; tgt = c.pend_addr; end
      end else if (branch_taken) begin
        n.pend = 1; n.pend_addr = branch_target;
      end
    end else begin
      if (resume && !halt_req) begin
        n.mode = M_RUN; n.pend = 0;
        if (c.pend) begin go = 1; rd = 1; tgt = c.pend_addr; end
      end
    end
    if (go) begin
      a     = (tgt / 4) * 4;
      n.mis = rd && (tgt % 4 != 0);
      if (a >= LIMIT) begin n.pc = RVEC; n.wrap = 1; end
      else n.pc = a;
    end
    return n;
  endfunction

  task automatic cycle();
    model_t mn;
    @(negedge clk);
    seen_next = pc_next;
    mn        = next_model(m);
    exp_next  = mn.pc;
    @(posedge clk);
    #1;
    m = mn;
  endtask

  task automatic idle_inputs();
    branch_taken = 0; branch_target = '0; stall = 0;
    halt_req = 0; resume = 0; fetch_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #12;
    checks++; if (pc_out !== RVEC) begin fails++; $display("FAIL reset_pc got=%0h want=%0h", pc_out, RVEC); end
    checks++; if (state !== M_BOOT) begin fails++; $display("FAIL reset_state got=%0d want=%0d", state, M_BOOT); end
    checks++; if ({fetch_valid, wrapped, misaligned} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b want=000", {fetch_valid, wrapped, misaligned}); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m = reset_model();
  endtask

  task automatic test_seq_wrap();
    logic [63:0] seq [5];
    seq = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd0};
    fetch_ready = 1;
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      checks++; if (fetch_valid !== 1'b0) begin fails++; $display("FAIL boot_fetch_valid cyc=%0d got=%b want=0", i, fetch_valid); end
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (pc_out !== seq[i]) begin fails++; $display("FAIL seq_pc step=%0d got=%0h want=%0h", i, pc_out, seq[i]); end
      checks++; if (wrapped !== (i == 4)) begin fails++; $display("FAIL seq_wrapped step=%0d got=%b want=%b", i, wrapped, (i == 4)); end
      checks++; if (fetch_valid !== 1'b1) begin fails++; $display("FAIL seq_fetch_valid step=%0d got=%b want=1", i, fetch_valid); end
      if (i < 4) cycle();
    end
  endtask

  task automatic test_fetch_hold();
    fetch_ready = 1; cycle();
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (pc_out !== 64'd4 || fetch_valid !== 1'b1) begin fails++; $display("FAIL hold_pc cyc=%0d got=%0h/%b want=4/1", i, pc_out, fetch_valid); end
      checks++; if (seen_next !== 64'd4) begin fails++; $display("FAIL hold_pc_next cyc=%0d got=%0h want=4", i, seen_next); end
    end
    fetch_ready = 1; cycle();
    checks++; if (pc_out !== 64'd8) begin fails++; $display("FAIL hold_release got=%0h want=8", pc_out); end
  endtask

  task automatic test_branch();
    fetch_ready = 0;
    branch_taken = 1; branch_target = 64'd4; cycle();
    checks++; if (pc_out !== 64'd4 || misaligned !== 1'b0) begin fails++; $display("FAIL br_aligned got=%0h/%b want=4/0", pc_out, misaligned); end
    branch_target = 64'hE; cycle();
    checks++; if (pc_out !== 64'hC || misaligned !== 1'b1) begin fails++; $display("FAIL br_misaligned got=%0h/%b want=c/1", pc_out, misaligned); end
    branch_taken = 0; cycle();
    checks++; if (pc_out !== 64'hC || misaligned !== 1'b0) begin fails++; $display("FAIL br_mis_pulse got=%0h/%b want=c/0", pc_out, misaligned); end
    branch_taken = 1; branch_target = 64'h20; cycle();
    branch_taken = 0;
    checks++; if (pc_out !== RVEC || wrapped !== 1'b1) begin fails++; $display("FAIL br_wrap got=%0h/%b want=0/1", pc_out, wrapped); end
  endtask

  task automatic test_stall_pending();
    logic [63:0] p0;
    p0 = pc_out;
    fetch_ready = 1; stall = 1; cycle();
    checks++; if (state !== M_STALL || fetch_valid !== 1'b0) begin fails++; $display("FAIL stall_enter got=%0d/%b want=2/0", state, fetch_valid); end
    branch_taken = 1; branch_target = 64'd8; cycle();
    branch_taken = 0;
    checks++; if (pc_out !== p0) begin fails++; $display("FAIL stall_hold1 got=%0h want=%0h", pc_out, p0); end
    cycle();
    checks++; if (pc_out !== p0 || state !== M_STALL) begin fails++; $display("FAIL stall_hold2 got=%0h/%0d want=%0h/2", pc_out, state, p0); end
    stall = 0; fetch_ready = 0; cycle();
    checks++; if (pc_out !== 64'd8 || state !== M_RUN) begin fails++; $display("FAIL stall_release got=%0h/%0d want=8/1", pc_out, state); end
  endtask

  task automatic test_halt();
    halt_req = 1; cycle(); halt_req = 0;
    checks++; if (state !== M_HALT || pc_out !== 64'd8 || fetch_valid !== 1'b0) begin fails++; $display("FAIL halt_enter got=%0d/%0h/%b want=3/8/0", state, pc_out, fetch_valid); end
    fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      stall = i[0]; branch_taken = ~i[0]; branch_target = 64'd0; cycle();
      checks++; if (state !== M_HALT || pc_out !== 64'd8) begin fails++; $display("FAIL halt_ignore cyc=%0d got=%0d/%0h want=3/8", i, state, pc_out); end
    end
    stall = 0; branch_taken = 0;
    halt_req = 1; resume = 1; cycle(); halt_req = 0;
    checks++; if (state !== M_HALT) begin fails++; $display("FAIL halt_wins got=%0d want=3", state); end
    fetch_ready = 0; cycle(); resume = 0;
    checks++; if (state !== M_RUN || pc_out !== 64'd8 || fetch_valid !== 1'b1) begin fails++; $display("FAIL resume got=%0d/%0h/%b want=1/8/1", state, pc_out, fetch_valid); end
  endtask

  task automatic test_reset_in_stall();
    stall = 1; cycle();
    branch_taken = 1; branch_target = 64'hC; cycle();
    branch_taken = 0;
    #2 reset = 1'b1;
    #1;
    checks++; if (pc_out !== RVEC || state !== M_BOOT || fetch_valid !== 1'b0) begin fails++; $display("FAIL async_reset got=%0h/%0d/%b want=0/0/0", pc_out, state, fetch_valid); end
    @(posedge clk);
    #1;
    reset = 1'b0; stall = 0; fetch_ready = 0;
    m = reset_model();
    cycle();
    checks++; if (fetch_valid !== 1'b0) begin fails++; $display("FAIL reboot_boot got=%b want=0", fetch_valid); end
    cycle();
    checks++; if (state !== M_RUN || pc_out !== RVEC) begin fails++; $display("FAIL reboot_run got=%0d/%0h want=1/0", state, pc_out); end
    cycle();
    checks++; if (pc_out !== RVEC) begin fails++; $display("FAIL reboot_no_redirect got=%0h want=0", pc_out); end
    fetch_ready = 1; cycle();
    checks++; if (pc_out !== 64'd4) begin fails++; $display("FAIL reboot_fetch got=%0h want=4", pc_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      halt_req      = ($urandom_range(0, 15) == 0);
      resume        = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      fetch_ready   = ($urandom_range(0, 3) != 0);
      branch_target = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 31));
      cycle();
      checks++; if (seen_next !== exp_next) begin fails++; $display("FAIL rnd_pc_next it=%0d got=%0h want=%0h", i, seen_next, exp_next); end
      checks++; if (pc_out !== m.pc) begin fails++; $display("FAIL rnd_pc it=%0d got=%0h want=%0h", i, pc_out, m.pc); end
      checks++; if (state !== m.mode) begin fails++; $display("FAIL rnd_state it=%0d got=%0d want=%0d", i, state, m.mode); end
      checks++; if (fetch_valid !== (m.mode == M_RUN)) begin fails++; $display("FAIL rnd_fetch_valid it=%0d got=%b want=%b", i, fetch_valid, (m.mode == M_RUN)); end
      checks++; if (wrapped !== m.wrap || misaligned !== m.mis) begin fails++; $display("FAIL rnd_pulses it=%0d got=%b%b want=%b%b", i, wrapped, misaligned, m.wrap, m.mis); end
    end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_fetch_hold();
    test_branch();
    test_stall_pending();
    test_halt();
    test_reset_in_stall();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the single-cycle core. Drives the program counter register's input and qualifies instruction fetch.
- Sequences the boot delay after reset, the sequential +4 advance, branch redirects, stalls and halt/resume.
- Applies the instruction-memory wrap-around rule: any next PC at or beyond PC_LIMIT becomes RESET_VECTOR.
- Sits between the branch/hazard logic and the PC register / instruction memory.

Parameters:
- ADDR_W, 64, PC width in bits.
- PC_LIMIT, 16, first byte address outside instruction memory; the wrap threshold.
- RESET_VECTOR, 0, PC value after reset and after a wrap.
- BOOT_CYCLES, 2, idle cycles after reset release before the first fetch; range 1..15.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-high reset.
- branch_taken  in  1  Redirect request, valid this cycle.
- branch_target  in  ADDR_W  Redirect address.
- stall  in  1  Hazard hold; level-sensitive.
- halt_req  in  1  Enter HALT; single-cycle pulse.
- resume  in  1  Leave HALT; single-cycle pulse.
- fetch_ready  in  1  Instruction memory accepts the current PC.
- pc_out  out  ADDR_W  Current PC; registered.
- pc_next  out  ADDR_W  Combinational next PC, fed to the PC register input.
- fetch_valid  out  1  pc_out is a live fetch request.
- wrapped  out  1  One-cycle pulse: the last update wrapped to RESET_VECTOR.
- misaligned  out  1  One-cycle pulse: the accepted branch_target had bits [1:0] != 0.
- state  out  2  BOOT=00, RUN=01, STALL=10, HALT=11.

Behaviour:
- Reset (asynchronous, active-high): pc_out=RESET_VECTOR, state=BOOT, boot counter=0, pend_valid=0, pend_addr=0, fetch_valid=0, wrapped=0, misaligned=0.
  - Reset asserted mid-operation discards any pending redirect and any stall/halt status.
- BOOT: pc_out holds; fetch_valid=0.
  - Counter increments each cycle; after BOOT_CYCLES cycles, state becomes RUN.
  - All inputs are ignored in BOOT.
- RUN: fetch_valid=1. Priority, highest first:
  1. halt_req -> HALT; pc holds.
  2. branch_taken -> pc_out <= align(branch_target) on the next edge, regardless of fetch_ready; this squashes the current fetch.
  3. stall -> STALL; pc holds.
  4. fetch_ready -> pc_out <= pc_out+4.
  5. Otherwise pc holds.
- STALL: fetch_valid=0; pc holds.
  - branch_taken is captured into pend_addr/pend_valid; a later branch overwrites an earlier one.
  - halt_req -> HALT; pend_valid is kept.
  - When stall deasserts: state becomes RUN. If pend_valid, pc_out <= pend_addr on that same edge and pend_valid is cleared.
- HALT: fetch_valid=0; pc holds; branch_taken and stall are ignored.
  - resume -> RUN. A pending redirect is applied on that edge; otherwise pc_out holds and is refetched.
  - halt_req and resume asserted together: halt_req wins.
- align(x) = {x[ADDR_W-1:2],2'b00}. misaligned pulses on the cycle the redirect is applied to pc_out.
- Wrap rule: applies to every pc_out update, both +4 and redirect.
  - If the candidate is >= PC_LIMIT (unsigned compare), pc_out <= RESET_VECTOR and wrapped pulses for one cycle.
  - +4 is computed modulo 2^ADDR_W; overflow is covered by the same compare.
- pc_next always equals the value pc_out takes on the next edge, so pc_next==pc_out when holding.
- There are no other state transitions; illegal state encodings return to BOOT.

Decomposition:
- Shared package rv_core_pkg holds:
  - State encoding constants: ST_BOOT, ST_RUN, ST_STALL, ST_HALT.
  - PC_STEP=4, ADDR_W default, RESET_VECTOR default.
- One natural sub-module, pc_wrap_align (combinational):
  - Takes the candidate address and PC_LIMIT.
  - Returns the aligned/wrapped address plus wrap and misalign flags.
- The FSM, boot counter and pending register stay in pc_sequencer.

Test Plan:
- Reset release, fetch_ready=1, BOOT_CYCLES=2 -> fetch_valid low for 2 cycles; then pc_out 0,4,8,12,0 with wrapped pulsing on the 12->0 step.
- RUN at pc=4, fetch_ready=0 for 3 cycles -> pc_out stays 4 and fetch_valid stays 1; on fetch_ready=1, pc_out=8.
- RUN at pc=4, branch_taken with target=0xE, fetch_ready=0 -> next pc_out=0xC, misaligned pulses once; with target=0x20 -> pc_out=0, wrapped pulses.
- Stall held 3 cycles with branch_taken (target 8) in cycle 2 -> pc holds, fetch_valid=0; on stall release, pc_out=8 and state=RUN.
- halt_req at pc=8, then stall/branch_taken toggled, then resume -> pc_out stays 8 through HALT; RUN resumes fetching 8.
- Reset asserted in STALL with a pending redirect -> pc_out=0 and state=BOOT immediately; after BOOT no redirect occurs and fetch starts at 0.
